// File: rtl/main_unit.sv
// main_unit: button-stepped six-state control unit with 8-bit data register
// and a free-running 4-digit display scan. Rev 1.0
`default_nettype none

module main_unit #(
  parameter int DEB_CYCLES = 16,
  parameter int SCAN_DIV   = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       count,
  input  logic [7:0] U,
  output logic [3:0] a,
  output logic [1:0] state,
  output logic [7:0] C_to_print,
  output logic [2:0] state_to_print
);

  typedef enum logic [2:0] {
    N0 = 3'd0,
    N1 = 3'd1,
    N2 = 3'd2,
    N3 = 3'd3,
    N4 = 3'd4,
    N5 = 3'd5
  } fsm_t;

  localparam logic [7:0] DEB_LAST = 8'(DEB_CYCLES - 1);
  localparam logic [7:0] DEB_SAT  = 8'(DEB_CYCLES);
  localparam int         PW       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);

  logic [7:0]    dc;
  logic          step;
  fsm_t          fsm;
  logic [7:0]    c_reg;
  logic [PW-1:0] presc;

  // Saturating at DEB_CYCLES keeps dc off DEB_LAST until count drops, so a
  // long press yields exactly one step and one low sample re-arms it.
  assign step = count && (dc == DEB_LAST);

  always_ff @(posedge clk) begin
    if (rst || !count) begin
      dc <= 8'd0;
    end else if (dc < DEB_SAT) begin
      dc <= dc + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm   <= N0;
      c_reg <= 8'h00;
    end else if (step) begin
      case (fsm)
        N0: begin
          c_reg <= U;
          fsm   <= U[0] ? N0 : N2;
        end
        N1: begin
          c_reg <= c_reg + U;
          fsm   <= U[4] ? N1 : N3;
        end
        N2: begin
          c_reg <= c_reg ^ U;
          fsm   <= U[7] ? N2 : N1;
        end
        N3: begin
          c_reg <= c_reg - U;
          fsm   <= U[5] ? N4 : N3;
        end
        N4: begin
          c_reg <= {c_reg[6:0], c_reg[7]};
          fsm   <= N5;
        end
        N5: begin
          c_reg <= c_reg & U;
          fsm   <= U[3] ? N0 : N5;
        end
        default: fsm <= N0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc <= '0;
      state <= 2'd0;
    end else if (presc == PRESC_LAST) begin
      presc <= '0;
      state <= state + 2'd1;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  assign a              = ~(4'b0001 << state);
  assign C_to_print     = c_reg;
  assign state_to_print = fsm;

endmodule

`default_nettype wire

// File: tb/tb_main_unit.sv
// tb_main_unit: scoreboard bench for main_unit; expected step results are
// queued by the stimulus and checked by a monitor keyed on the step strobe.
`default_nettype none

module tb_main_unit;

  localparam int DEB = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       count = 1'b0;
  logic [7:0] U = 8'h00;
  logic [3:0] a;
  logic [1:0] state;
  logic [7:0] C_to_print;
  logic [2:0] state_to_print;

  main_unit #(.DEB_CYCLES(16), .SCAN_DIV(16)) dut (
    .clk            (clk),
    .rst            (rst),
    .count          (count),
    .U              (U),
    .a              (a),
    .state          (state),
    .C_to_print     (C_to_print),
    .state_to_print (state_to_print)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         st;
    logic [7:0] c;
    int         at;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: step is sampled before the edge, results checked just after it.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      if (dut.step === 1'b1 && rst === 1'b0) begin
        #1;
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL extra_step: got a step at cycle %0d, want none", cyc);
        end else begin
          e = q.pop_front();
          chk("step_cycle", cyc, e.at);
          chk("step_state", int'(state_to_print), e.st);
          chk("step_C", int'(C_to_print), int'(e.c));
        end
      end
    end
  end

  // Bounce of three single-cycle highs, then a long stable press.
  task automatic press(input logic [7:0] u, input int highs,
                       input int est, input logic [7:0] ec);
    exp_t e;
    U = u;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); count = 1'b1;
      @(negedge clk); count = 1'b0;
    end
    @(negedge clk);
    count = 1'b1;
    e.st = est;
    e.c  = ec;
    e.at = cyc + DEB;
    q.push_back(e);
    repeat (highs) @(negedge clk);
    count = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  logic [7:0] seq_u [11] = '{8'h01, 8'h00, 8'h8C, 8'h46, 8'h10, 8'h00,
                             8'h10, 8'h36, 8'h10, 8'h00, 8'h08};
  int         seq_s [11] = '{0, 2, 2, 1, 1, 3, 3, 4, 5, 5, 0};
  logic [7:0] seq_c [11] = '{8'h01, 8'h00, 8'h8C, 8'hCA, 8'hDA, 8'hDA,
                             8'hCA, 8'h94, 8'h29, 8'h00, 8'h00};
  int         scan_at [4] = '{16, 32, 48, 64};
  int         scan_st [4] = '{1, 2, 3, 0};
  logic [3:0] scan_a  [4] = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    bad++;
    total++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset
    rst = 1'b1;
    repeat (10) @(negedge clk);
    chk("reset_C", int'(C_to_print), 0);
    chk("reset_state_code", int'(state_to_print), 0);
    chk("reset_scan", int'(state), 0);
    chk("reset_anode", int'(a), 4'b1110);
    rst = 1'b0;

    // Short glitches must not step
    for (int i = 0; i < 7; i++) begin
      @(negedge clk); count = 1'b1;
      @(negedge clk); count = 1'b0;
    end
    repeat (2) @(negedge clk);
    chk("glitch_state_code", int'(state_to_print), 0);
    chk("glitch_C", int'(C_to_print), 0);

    // First seven presses reach N3 with C=CA; first one held 50 cycles
    for (int i = 0; i < 7; i++)
      press(seq_u[i], (i == 0) ? 50 : 20 + 3 * i, seq_s[i], seq_c[i]);
    chk("pre_reset_state_code", int'(state_to_print), 3);
    chk("pre_reset_C", int'(C_to_print), 8'hCA);

    // Reset in the middle of a high run; remaining highs are too few to step
    U = 8'h36;
    @(negedge clk); count = 1'b1;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    count = 1'b0;
    repeat (2) @(negedge clk);
    chk("midreset_state_code", int'(state_to_print), 0);
    chk("midreset_C", int'(C_to_print), 0);

    // Full eleven-press sequence from N0
    for (int i = 0; i < 11; i++)
      press(seq_u[i], 30, seq_s[i], seq_c[i]);
    chk("seq_end_state_code", int'(state_to_print), 0);

    // Scan timing relative to reset release
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 1; i <= 64; i++) begin
      @(posedge clk);
      #1;
      for (int j = 0; j < 4; j++) begin
        if (i == scan_at[j]) begin
          chk("scan_index", int'(state), scan_st[j]);
          chk("scan_anode", int'(a), int'(scan_a[j]));
        end
      end
    end

    repeat (4) @(negedge clk);
    chk("pending_steps", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/main_unit.md
# main_unit

Button-stepped control unit for the lab board: a debounced `count` press advances a six-state machine (N0..N5) whose transitions are selected by the 8-bit input vector `U`. Each step also updates an 8-bit data register `C`. The block exposes `C` and the state code for printing, plus a free-running 4-digit display scan (index and active-low anode select). It sits between the board buttons/switches and the display driver; segment decoding is done downstream.

## Interface
- `DEB_CYCLES`, default 16: consecutive high samples of `count` required to register one press.
- `SCAN_DIV`, default 16: clock cycles per display-scan step.
- `clk` in 1: single system clock; all state updates on its rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `count` in 1: raw step button; bouncy, driven synchronously to `clk`.
- `U` in 8: condition/operand vector, sampled in the step cycle.
- `a` out 4: active-low one-hot anode select, `a = ~(4'b0001 << state)`.
- `state` out 2: display scan index 0..3.
- `C_to_print` out 8: current value of data register `C`.
- `state_to_print` out 3: FSM state code; N0=0, N1=1, N2=2, N3=3, N4=4, N5=5.

## Operation
- Debounce:
  - 8-bit counter `dc`; cleared in any cycle where `count`=0.
  - While `count`=1, `dc` increments and saturates at `DEB_CYCLES`.
  - One-cycle `step` is asserted in the cycle where `count`=1 and `dc`=`DEB_CYCLES`-1.
  - No further step occurs until `count` has been sampled low at least once (a single low cycle re-arms the detector).
  - High pulses shorter than `DEB_CYCLES` produce no step.
- FSM, evaluated only when `step`=1, using current state and current `U`:
  - N0: `U[0]`=1 -> N0, else -> N2.
  - N2: `U[7]`=1 -> N2, else -> N1.
  - N1: `U[4]`=1 -> N1, else -> N3.
  - N3: `U[5]`=1 -> N4, else -> N3.
  - N4: unconditional -> N5.
  - N5: `U[3]`=1 -> N0, else -> N5.
  - Codes 6 and 7 are unreachable; if ever held, the next step goes to N0 with `C` unchanged.
- Datapath, on `step`, keyed by the current (pre-transition) state; all arithmetic is mod 256:
  - N0: `C` <= `U`.
  - N1: `C` <= `C` + `U`.
  - N2: `C` <= `C` ^ `U`.
  - N3: `C` <= `C` - `U`.
  - N4: `C` <= {`C[6:0]`, `C[7]`} (rotate left).
  - N5: `C` <= `C` & `U`.
- Scan:
  - Prescaler counts 0..`SCAN_DIV`-1; `state` increments, wrapping 3->0, when the prescaler wraps.
  - Scanning runs independently of `step`.

## Timing
- Reset: state N0 (`state_to_print`=0), `C`=0x00, `dc`=0, prescaler 0, `state`=0, `a`=4'b1110. `rst` has priority over `step`.
- Step latency: FSM state and `C` change on the `DEB_CYCLES`-th consecutive rising edge at which `count`=1. Outputs are registered and valid after that edge.
- Exactly one step per stable press, however long `count` stays high.
- `U` only needs to be stable in the step cycle.
- Scan: `state` advances every `SCAN_DIV` cycles; full rotation every 4·`SCAN_DIV` cycles. `a` is combinational from `state`.
- `rst` asserted mid-press clears `dc`; after reset, a new full `DEB_CYCLES` run of highs is needed to step.

## Test plan
- Reset for 10 cycles -> `C_to_print`=0x00, `state_to_print`=0, `state`=0, `a`=1110.
- Seven alternating single-cycle highs on `count` with `U`=0x00 -> no change to state or `C`.
- From N0 with `U`=0x01, one bounce-then-50-cycle-high press -> state N0, `C`=0x01. Exactly one step, landing on the 16th high edge.
- Press sequence, each press a bounce then a long high, with `U` = 0x01, 0x00, 0x8C, 0x46, 0x10, 0x00, 0x10, 0x36, 0x10, 0x00, 0x08:
  - Required states: N0, N2, N2, N1, N1, N3, N3, N4, N5, N5, N0.
  - Required `C`: 01, 00, 8C, CA, DA, DA, CA, 94, 29, 00, 00.
  - Bounce cycles between presses must not create extra steps.
- Assert `rst` for 1 cycle while in N3 with `C`=0xCA, in the middle of a high run -> N0, `C`=0x00. The remaining highs of that press (fewer than 16) cause no step.
- After reset, `state` and `a` must read: cycle 16 -> 1 / 1101; cycle 32 -> 2 / 1011; cycle 48 -> 3 / 0111; cycle 64 -> 0 / 1110.
